pipelined_alu_core: RTL and testbench
=====================================

// Module: pipelined_alu_core
// PURPOSE
//  Parametrised successor to the fixed 32-bit 5-stage pipelined processor datapath.
//  3-stage in-order core: ID, EX, MEM, with commit on the MEM exit edge.
//  Adds valid/ready instruction intake, a load handshake with stalling, r0 hardwired to zero,
//  OR/XOR ops and hazard handling; sits between the instruction source and the data-memory port.
// PARAMETERS
//  XLEN    32  datapath/register width (>=8)
//  REG_AW  5   register index width (1..5); NREGS=2**REG_AW; low REG_AW bits of each instr field used
// PORTS
//  clk            in   1       rising-edge clock
//  reset          in   1       synchronous, active-high
//  instruction    in   32      [31:28]=op [25:21]=rs [20:16]=rt [15:11]=rd
//  inst_valid     in   1       instruction present
//  inst_ready     out  1       core accepts instruction this cycle
//  data_in        in   XLEN    load data
//  data_in_valid  in   1       data_in valid this cycle
//  load_req       out  1       MEM stage holds a LOAD awaiting data
//  load_addr      out  XLEN    rs operand of the LOAD in MEM
//  result         out  XLEN    committed write value (registered)
//  result_rd      out  REG_AW  committed destination (registered)
//  result_valid   out  1       1-cycle pulse per committed writing instruction
// BEHAVIOUR
//  - Reset is synchronous, active-high; one clock domain.
//  - Ops: 0 ADD rs+rt, 1 SUB rs-rt (mod 2^XLEN), 2 AND, 3 LOAD rd<=data_in, 4 OR, 5 XOR.
//  - Opcodes 6-15 are NOP: flow through the pipe, no write, no result_valid.
//  - Reset: all stage valids=0, all regs=0, result=0, result_rd=0, result_valid=0.
//  - Reset: load_req=0; inst_ready=1 on the cycle after reset deasserts.
//  - Reset asserted mid-flight flushes every stage; no commit occurs on that edge.
//  - Accept on inst_valid&&inst_ready at edge N -> ID. Then EX@N+1, MEM@N+2, commit@N+3.
//  - result_valid is high in the cycle after N+3 (3-cycle latency with no stalls).
//  - Reg read in ID is combinational with write-through: a same-edge commit is seen.
//  - r0 reads 0. A write to rd=0 is discarded, but result_valid still pulses with result_rd=0.
//  - Load stall: MEM holds LOAD && !data_in_valid -> MEM/EX/ID hold, inst_ready=0.
//  - During a load stall, nothing commits.
//  - LOAD commits data_in on the edge where data_in_valid=1. data_in is ignored when load_req=0.
//  - load_req=1 exactly while MEM holds a LOAD; load_addr is stable across stall cycles.
//  - Hazard stall: ID held and a bubble (valid=0) enters EX; inst_ready=0.
//  - inst_ready = !ID_full || ID advancing. ID refills on the same edge it drains (no bubble on back-to-back).
//  - Sources: ALU ops read rs,rt; LOAD reads rs only.
//  - A source with index 0 never causes a hazard.
//  - Simultaneous hazard and load stall: the load stall wins; the pipe holds entirely.
// CONFIGURATION
//  FORWARDING_EN defined:
//   - Operands latched into EX take priority: EX ALU result > MEM value > regfile.
//   - MEM value is the ALU result, or data_in for a completing LOAD.
//   - Only load-use (EX holds LOAD, rd matches an ID source) stalls ID, for 1 cycle.
//  FORWARDING_EN undefined:
//   - No bypass.
//   - ID stalls while EX or MEM holds a valid writer whose rd matches an ID source.
//   - Dependent instruction issues after the producer commits (write-through read).
// TESTING
//  1 reset; ADD r1=r0+r0 -> result_valid 3 cycles after accept, result=0, rd=1; all regs 0
//  2 LOAD r1 data_in=5 (valid immediately); LOAD r2 =7; ADD r3=r1+r2
//    -> r3 commit result=12; SUB r4=r2-r1 -> 2; SUB r5=r1-r2 -> 2^XLEN-2
//  3 back-to-back ADD r1=r2+r3 (r2=7,r3=5); ADD r4=r1+r1
//    -> FORWARDING_EN: no stall, r4=24; without it: 2 bubbles, r4=24, inst_ready low 2 cycles
//  4 LOAD r6 with data_in_valid held low 4 cycles, then 9
//    -> load_req high 5 cycles, inst_ready low, load_addr stable, r6=9 committed once
//  5 LOAD r7 followed by ADD r8=r7+r0 (FORWARDING_EN) -> exactly 1 bubble, r8=value loaded
//  6 reset asserted while 3 instrs in flight -> no result_valid after the reset edge; ADD r1=r0+r0 then commits 0
//    also: ADD to rd=0 -> result_valid=1, rd=0, r0 still reads 0; op 0xF -> no result_valid

Source files
------------

// File: rtl/pipelined_alu_core_if.sv
// pipelined_alu_core_if: instruction intake, load port and commit bus of pipelined_alu_core
interface pipelined_alu_core_if #(
  parameter int XLEN = 32,
  parameter int REG_AW = 5
);
  logic [31:0] instruction;
  logic inst_valid;
  logic inst_ready;
  logic [XLEN-1:0] data_in;
  logic data_in_valid;
  logic load_req;
  logic [XLEN-1:0] load_addr;
  logic [XLEN-1:0] result;
  logic [REG_AW-1:0] result_rd;
  logic result_valid;
  modport master (
    output instruction, inst_valid, data_in, data_in_valid,
    input inst_ready, load_req, load_addr, result, result_rd, result_valid
  );
  modport slave (
    input instruction, inst_valid, data_in, data_in_valid,
    output inst_ready, load_req, load_addr, result, result_rd, result_valid
  );
endinterface

// File: rtl/pipelined_alu_core.sv
// pipelined_alu_core: 3-stage ID/EX/MEM ALU core with load stall; define FORWARDING_EN for operand bypassing
module pipelined_alu_core #(
  parameter int XLEN = 32,
  parameter int REG_AW = 5
) (
  input logic clk,
  input logic reset,
  pipelined_alu_core_if.slave bus
);
  localparam int NREGS = 2 ** REG_AW;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_LOAD = 4'd3;
  localparam logic [3:0] OP_OR = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  function automatic logic f_wr(input logic [3:0] op);
    return op < 4'd6;
  endfunction
  function automatic logic f_alu(input logic [3:0] op);
    return op < 4'd6 && op != OP_LOAD;
  endfunction
  logic [XLEN-1:0] r_rf [NREGS];
  logic r_id_v, r_ex_v, r_mem_v, r_result_valid;
  logic [3:0] r_id_op, r_ex_op, r_mem_op;
  logic [REG_AW-1:0] r_id_rs, r_id_rt, r_id_rd, r_ex_rd, r_mem_rd, r_result_rd;
  logic [XLEN-1:0] r_ex_a, r_ex_b, r_mem_val, r_mem_a, r_result;
  logic w_lstall, w_wr, w_haz, w_ready, w_use_rs, w_use_rt, w_ex_hit, w_unused;
  logic [XLEN-1:0] w_mem_val, w_ex_res, w_rf_a, w_rf_b, w_op_a, w_op_b;
  assign w_unused = ^{bus.instruction[27:26], bus.instruction[10:0]};
  assign w_lstall = r_mem_v && r_mem_op == OP_LOAD && !bus.data_in_valid;
  assign w_wr = r_mem_v && !w_lstall && f_wr(r_mem_op);
  assign w_mem_val = r_mem_op == OP_LOAD ? bus.data_in : r_mem_val;
  assign w_use_rs = r_id_v && f_wr(r_id_op) && r_id_rs != '0;
  assign w_use_rt = r_id_v && f_alu(r_id_op) && r_id_rt != '0;
  assign w_ex_hit = r_ex_v && f_wr(r_ex_op) &&
                    ((w_use_rs && r_ex_rd == r_id_rs) || (w_use_rt && r_ex_rd == r_id_rt));
  assign w_ready = !w_lstall && !w_haz;
  assign w_ex_res = r_ex_op == OP_ADD ? r_ex_a + r_ex_b :
                    r_ex_op == OP_SUB ? r_ex_a - r_ex_b :
                    r_ex_op == OP_AND ? r_ex_a & r_ex_b :
                    r_ex_op == OP_OR  ? r_ex_a | r_ex_b :
                    r_ex_op == OP_XOR ? r_ex_a ^ r_ex_b : '0;
  // write-through: a value committing on this edge is visible to the ID read
  assign w_rf_a = r_id_rs == '0 ? '0 : (w_wr && r_mem_rd == r_id_rs) ? w_mem_val : r_rf[r_id_rs];
  assign w_rf_b = r_id_rt == '0 ? '0 : (w_wr && r_mem_rd == r_id_rt) ? w_mem_val : r_rf[r_id_rt];
`ifdef FORWARDING_EN
  assign w_haz = w_ex_hit && r_ex_op == OP_LOAD;
  assign w_op_a = (r_ex_v && f_wr(r_ex_op) && r_ex_rd == r_id_rs && r_id_rs != '0) ? w_ex_res :
                  (r_mem_v && f_wr(r_mem_op) && r_mem_rd == r_id_rs && r_id_rs != '0) ? w_mem_val : w_rf_a;
  assign w_op_b = (r_ex_v && f_wr(r_ex_op) && r_ex_rd == r_id_rt && r_id_rt != '0) ? w_ex_res :
                  (r_mem_v && f_wr(r_mem_op) && r_mem_rd == r_id_rt && r_id_rt != '0) ? w_mem_val : w_rf_b;
`else
  assign w_haz = w_ex_hit || (r_mem_v && f_wr(r_mem_op) &&
                 ((w_use_rs && r_mem_rd == r_id_rs) || (w_use_rt && r_mem_rd == r_id_rt)));
  assign w_op_a = w_rf_a;
  assign w_op_b = w_rf_b;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      r_id_v <= 1'b0;
      r_ex_v <= 1'b0;
      r_mem_v <= 1'b0;
      r_id_op <= '0;
      r_id_rs <= '0;
      r_id_rt <= '0;
      r_id_rd <= '0;
      r_ex_op <= '0;
      r_ex_rd <= '0;
      r_ex_a <= '0;
      r_ex_b <= '0;
      r_mem_op <= '0;
      r_mem_rd <= '0;
      r_mem_val <= '0;
      r_mem_a <= '0;
      r_result <= '0;
      r_result_rd <= '0;
      r_result_valid <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else begin
      r_result_valid <= w_wr;
      if (w_wr) begin
        r_result <= w_mem_val;
        r_result_rd <= r_mem_rd;
      end
      if (w_wr && r_mem_rd != '0) r_rf[r_mem_rd] <= w_mem_val;
      if (!w_lstall) begin
        r_mem_v <= r_ex_v;
        r_mem_op <= r_ex_op;
        r_mem_rd <= r_ex_rd;
        r_mem_val <= w_ex_res;
        r_mem_a <= r_ex_a;
        r_ex_v <= r_id_v && !w_haz;
        r_ex_op <= r_id_op;
        r_ex_rd <= r_id_rd;
        r_ex_a <= w_op_a;
        r_ex_b <= w_op_b;
      end
      if (w_ready) begin
        r_id_v <= bus.inst_valid;
        r_id_op <= bus.instruction[31:28];
        r_id_rs <= bus.instruction[21 +: REG_AW];
        r_id_rt <= bus.instruction[16 +: REG_AW];
        r_id_rd <= bus.instruction[11 +: REG_AW];
      end
    end
  end
  assign bus.inst_ready = w_ready;
  assign bus.load_req = r_mem_v && r_mem_op == OP_LOAD;
  assign bus.load_addr = r_mem_a;
  assign bus.result = r_result;
  assign bus.result_rd = r_result_rd;
  assign bus.result_valid = r_result_valid;
endmodule

// File: tb/tb_pipelined_alu_core.sv
// tb_pipelined_alu_core: table vectors plus hand sequences, commits checked by an in-order scoreboard
module tb_pipelined_alu_core;
  typedef struct {logic [4:0] rd; logic [31:0] val;} sb_t;
  typedef struct {logic [3:0] op; logic [4:0] rs, rt, rd; logic [31:0] ld, exp;} vec_t;
`ifdef FORWARDING_EN
  localparam int EXP_RAW_WAIT = 0;
  localparam int EXP_LDU_WAIT = 1;
`else
  localparam int EXP_RAW_WAIT = 2;
  localparam int EXP_LDU_WAIT = 2;
`endif
  logic clk, reset;
  int n_pass, n_total, ld_lat, wait_cnt, w, cnt_req, cnt_nr;
  sb_t sb_q[$];
  logic [31:0] ld_q[$];
  vec_t vt[15];
  pipelined_alu_core_if #(.XLEN(32), .REG_AW(5)) bus();
  pipelined_alu_core #(.XLEN(32), .REG_AW(5)) dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "timeout");
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask
  task automatic sb_task();
    sb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.result_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_commit: got result_valid=1 rd=%0d result=%0h expected no commit",
                   bus.result_rd, bus.result);
        end else begin
          e = sb_q.pop_front();
          chk("commit_rd", {27'd0, bus.result_rd}, {27'd0, e.rd});
          chk("commit_val", bus.result, e.val);
        end
      end
    end
  endtask
  task automatic resp_task();
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        bus.data_in_valid = 1'b0;
        wait_cnt = 0;
      end else begin
        if (bus.data_in_valid && ld_q.size() > 0) begin
          void'(ld_q.pop_front());
          wait_cnt = 0;
        end
        bus.data_in_valid = 1'b0;
        bus.data_in = $urandom;
        if (bus.load_req) begin
          if (wait_cnt >= ld_lat && ld_q.size() > 0) begin
            bus.data_in = ld_q[0];
            bus.data_in_valid = 1'b1;
          end else wait_cnt++;
        end
      end
    end
  endtask
  task automatic issue(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] ld, input logic [31:0] exp,
                       output int waits);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    @(negedge clk);
    bus.instruction = {op, 2'b00, rs, rt, rd, 11'd0};
    bus.inst_valid = 1'b1;
    while (!acc && n < 40) begin
      #4;
      acc = bus.inst_ready;
      @(posedge clk);
      if (!acc) begin
        n++;
        @(negedge clk);
      end
    end
    #1;
    bus.inst_valid = 1'b0;
    waits = n;
    if (!acc) begin
      n_total++;
      $display("FAIL issue_timeout: got inst_ready=0 for %0d cycles expected acceptance", n);
    end else if (op < 4'd6) begin
      sb_q.push_back('{rd, exp});
      if (op == 4'd3) ld_q.push_back(ld);
    end
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    n_total++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d outstanding results expected 0", sb_q.size());
    repeat (4) @(posedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.inst_valid = 1'b0;
    sb_q.delete();
    ld_q.delete();
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("reset_no_commit", {31'd0, bus.result_valid}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("reset_inst_ready", {31'd0, bus.inst_ready}, 32'd1);
    chk("reset_load_req", {31'd0, bus.load_req}, 32'd0);
    chk("reset_result_valid", {31'd0, bus.result_valid}, 32'd0);
    chk("reset_result", bus.result, 32'd0);
    chk("reset_result_rd", {27'd0, bus.result_rd}, 32'd0);
  endtask
  initial begin
    vt[0]  = '{4'd3, 5'd0, 5'd0, 5'd1,  32'd5, 32'd5};
    vt[1]  = '{4'd3, 5'd0, 5'd0, 5'd2,  32'd7, 32'd7};
    vt[2]  = '{4'd0, 5'd1, 5'd2, 5'd3,  32'd0, 32'd12};
    vt[3]  = '{4'd1, 5'd2, 5'd1, 5'd4,  32'd0, 32'd2};
    vt[4]  = '{4'd1, 5'd1, 5'd2, 5'd5,  32'd0, 32'hFFFF_FFFE};
    vt[5]  = '{4'd2, 5'd3, 5'd2, 5'd6,  32'd0, 32'd4};
    vt[6]  = '{4'd4, 5'd3, 5'd1, 5'd7,  32'd0, 32'd13};
    vt[7]  = '{4'd5, 5'd3, 5'd2, 5'd8,  32'd0, 32'd11};
    vt[8]  = '{4'd0, 5'd5, 5'd4, 5'd9,  32'd0, 32'd0};
    vt[9]  = '{4'd0, 5'd3, 5'd3, 5'd0,  32'd0, 32'd24};
    vt[10] = '{4'd0, 5'd0, 5'd3, 5'd10, 32'd0, 32'd12};
    vt[11] = '{4'd15, 5'd1, 5'd2, 5'd11, 32'd0, 32'd0};
    vt[12] = '{4'd0, 5'd10, 5'd1, 5'd11, 32'd0, 32'd17};
    vt[13] = '{4'd6, 5'd3, 5'd4, 5'd12, 32'd0, 32'd0};
    vt[14] = '{4'd5, 5'd11, 5'd4, 5'd12, 32'd0, 32'd19};
    n_pass = 0;
    n_total = 0;
    ld_lat = 0;
    wait_cnt = 0;
    reset = 1'b1;
    bus.instruction = '0;
    bus.inst_valid = 1'b0;
    bus.data_in = '0;
    bus.data_in_valid = 1'b0;
    fork
      sb_task();
      resp_task();
    join_none
    do_reset();
    // 3-cycle latency of an isolated ADD
    issue(4'd0, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, w);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      chk("latency", {31'd0, bus.result_valid}, (k == 3) ? 32'd1 : 32'd0);
    end
    drain();
    for (int i = 0; i < 15; i++) issue(vt[i].op, vt[i].rs, vt[i].rt, vt[i].rd, vt[i].ld, vt[i].exp, w);
    drain();
    // RAW on back-to-back ALU ops: stall length seen by the next instruction
    issue(4'd3, 5'd0, 5'd0, 5'd3, 32'd5, 32'd5, w);
    drain();
    issue(4'd0, 5'd2, 5'd3, 5'd1, 32'd0, 32'd12, w);
    issue(4'd0, 5'd1, 5'd1, 5'd4, 32'd0, 32'd24, w);
    issue(4'd15, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, w);
    chk("raw_stall_cycles", w, EXP_RAW_WAIT);
    drain();
    // slow load: data_in_valid low for 4 cycles
    ld_lat = 4;
    issue(4'd3, 5'd2, 5'd0, 5'd6, 32'd9, 32'd9, w);
    cnt_req = 0;
    cnt_nr = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      #2;
      if (bus.load_req) begin
        cnt_req++;
        chk("load_addr", bus.load_addr, 32'd7);
        if (!bus.data_in_valid) begin
          cnt_nr++;
          chk("stall_inst_ready", {31'd0, bus.inst_ready}, 32'd0);
        end
      end
    end
    chk("load_req_cycles", cnt_req, 32'd5);
    chk("load_stall_cycles", cnt_nr, 32'd4);
    drain();
    ld_lat = 0;
    // load-use
    issue(4'd3, 5'd0, 5'd0, 5'd7, 32'd21, 32'd21, w);
    issue(4'd0, 5'd7, 5'd0, 5'd8, 32'd0, 32'd21, w);
    issue(4'd15, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, w);
    chk("load_use_stall_cycles", w, EXP_LDU_WAIT);
    drain();
    // reset with three instructions in flight
    issue(4'd0, 5'd2, 5'd3, 5'd9, 32'd0, 32'd12, w);
    issue(4'd0, 5'd3, 5'd2, 5'd10, 32'd0, 32'd12, w);
    issue(4'd0, 5'd0, 5'd2, 5'd11, 32'd0, 32'd7, w);
    do_reset();
    issue(4'd0, 5'd2, 5'd3, 5'd1, 32'd0, 32'd0, w);
    issue(4'd3, 5'd0, 5'd0, 5'd2, 32'd3, 32'd3, w);
    issue(4'd0, 5'd2, 5'd2, 5'd0, 32'd0, 32'd6, w);
    issue(4'd0, 5'd0, 5'd2, 5'd5, 32'd0, 32'd3, w);
    issue(4'd15, 5'd2, 5'd2, 5'd6, 32'd0, 32'd0, w);
    drain();
    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
